mem_port_sched: RTL and testbench

- Scheduler that shares the single uBio memory port between the instruction-fetch requester and the execute-stage load/store requester.
- Sits between the cycle controller's FETCH/EXECUTE consumers and the external memory.
- Grants one requester at a time, holds address, data and write-enable stable until memory acknowledges, then returns read data and a one-cycle done pulse.
- Drives a stall line back to the cycle controller while any access is outstanding.

---
 rtl/mem_port_sched_pkg.sv | 24 ++
 rtl/mem_port_sched_wdog.sv | 36 +++
 rtl/mem_port_sched.sv | 157 +++++++++++++++
 tb/tb_mem_port_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_sched_pkg.sv
// Shared encodings and default widths for the uBio memory port scheduler.
// Cycle phases are listed for the cycle controller that consumes stall.
package mem_port_sched_pkg;

    localparam int AW_DEF      = 8;
    localparam int DW_DEF      = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_FETCH   = 3'd1,
        PH_DECODE  = 3'd2,
        PH_EXECUTE = 3'd3,
        PH_WBACK   = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_EX = 2'd2,
        S_DONE    = 2'd3
    } sched_state_e;

endpackage

// File: rtl/mem_port_sched_wdog.sv
// Access watchdog: counts BUSY cycles without ack; used under MEM_TIMEOUT_EN.
// expired fires on the edge where the count would reach TIMEOUT.
module mem_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one memory port between fetch and execute; ex has fixed priority.
// Optional access timeout with sticky err is enabled by MEM_TIMEOUT_EN.
module mem_port_sched
    import mem_port_sched_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          ex_req,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    output logic [DW-1:0] ex_rdata,
    output logic          ex_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          err
);

    sched_state_e  state_q, state_d;
    logic          sel_ex_q, sel_ex_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ex_rdata_q, ex_rdata_d;
    logic          busy;
    logic          expired;

    assign busy = (state_q == S_BUSY_IF) || (state_q == S_BUSY_EX);

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (!busy),
        .run     (busy && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (expired) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign expired        = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_ex_d    = sel_ex_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ex_rdata_d  = ex_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (ex_req) begin
                    sel_ex_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ex_we;
                    mem_addr_d  = ex_addr;
                    mem_wdata_d = ex_wdata;
                    state_d     = S_BUSY_EX;
                end else if (if_req) begin
                    sel_ex_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    state_d     = S_BUSY_IF;
                end
            end
            S_BUSY_IF, S_BUSY_EX: begin
                // ack on the timeout edge completes normally
                if (mem_ack) begin
                    if (sel_ex_q) ex_rdata_d = mem_rdata;
                    else          if_rdata_d = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                end else if (expired) begin
                    if (sel_ex_q) ex_rdata_d = '0;
                    else          if_rdata_d = '0;
                    mem_req_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sel_ex_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            ex_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_ex_q    <= sel_ex_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ex_rdata_q  <= ex_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign ex_rdata  = ex_rdata_q;
    assign if_done   = (state_q == S_DONE) && !sel_ex_q;
    assign ex_done   = (state_q == S_DONE) && sel_ex_q;
    // DONE is the guard cycle, so a still-high req does not stall there
    assign stall     = (if_req || ex_req) && (state_q != S_DONE);

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched; timeout scenario follows MEM_TIMEOUT_EN.
module tb_mem_port_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_req;
    logic [7:0] if_addr;
    logic [7:0] if_rdata;
    logic       if_done;
    logic       ex_req;
    logic       ex_we;
    logic [7:0] ex_addr;
    logic [7:0] ex_wdata;
    logic [7:0] ex_rdata;
    logic       ex_done;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       stall;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int n_if     = 0;
    int n_ex     = 0;
    int n_acc    = 0;
    logic req_prev = 1'b0;

    mem_port_sched #(
        .AW      (8),
        .DW      (8),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .ex_req    (ex_req),
        .ex_we     (ex_we),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_rdata  (ex_rdata),
        .ex_done   (ex_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_done) n_if = n_if + 1;
        if (ex_done) n_ex = n_ex + 1;
        if (mem_req && !req_prev) n_acc = n_acc + 1;
        req_prev = mem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_if  = 0;
        n_ex  = 0;
        n_acc = 0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 8'h00;
        ex_req    = 1'b0;
        ex_we     = 1'b0;
        ex_addr   = 8'h00;
        ex_wdata  = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;
        step();
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_rdata, ex_rdata,
             if_done, ex_done, stall, err} !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0",
                {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, ex_rdata,
                 if_done, ex_done, stall, err});
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        clr_counts();
        if_req  = 1'b1;
        if_addr = 8'h10;
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr, stall} !== {1'b1, 1'b0, 8'h10, 1'b1}) begin
            failures++;
            $display("FAIL fetch_grant req/we/addr/stall got %b/%b/%h/%b want 1/0/10/1",
                mem_req, mem_we, mem_addr, stall);
        end
        if_addr = 8'hEE;
        step();
        step();
        checks++;
        if ({mem_req, mem_addr, if_done} !== {1'b1, 8'h10, 1'b0}) begin
            failures++;
            $display("FAIL fetch_hold req/addr/done got %b/%h/%b want 1/10/0",
                mem_req, mem_addr, if_done);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        checks++;
        if ({if_done, if_rdata, stall, mem_req, ex_done} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL fetch_done done/rdata/stall/req/exdone got %b/%h/%b/%b/%b want 1/a5/0/0/0",
                if_done, if_rdata, stall, mem_req, ex_done);
        end
        if_req = 1'b0;
        step();
        checks++;
        if ({if_done, if_rdata, n_if, n_acc} !== {1'b0, 8'hA5, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL fetch_after done/rdata/ndone/nacc got %b/%h/%0d/%0d want 0/a5/1/1",
                if_done, if_rdata, n_if, n_acc);
        end
    endtask

    task automatic test_store();
        clr_counts();
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
        step();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, if_done, ex_done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ack req/ifd/exd got %b/%b/%b want 0/0/0",
                mem_req, if_done, ex_done);
        end
        ex_req   = 1'b1;
        ex_we    = 1'b1;
        ex_addr  = 8'h20;
        ex_wdata = 8'h3C;
        step();
        ex_wdata = 8'h00;
        ex_we    = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h20, 8'h3C}) begin
            failures++;
            $display("FAIL store_grant req/we/addr/wdata got %b/%b/%h/%h want 1/1/20/3c",
                mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'h77;
        step();
        mem_ack = 1'b0;
        checks++;
        if ({ex_done, if_done, mem_req} !== 3'b100) begin
            failures++;
            $display("FAIL store_done exd/ifd/req got %b/%b/%b want 1/0/0",
                ex_done, if_done, mem_req);
        end
        ex_req = 1'b0;
        step();
        step();
        checks++;
        if ({n_ex, n_if, n_acc} !== {32'd1, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL store_counts nex/nif/nacc got %0d/%0d/%0d want 1/0/1",
                n_ex, n_if, n_acc);
        end
    endtask

    task automatic test_contention();
        clr_counts();
        if_req  = 1'b1;
        if_addr = 8'h30;
        ex_req  = 1'b1;
        ex_we   = 1'b0;
        ex_addr = 8'h40;
        step();
        ex_addr = 8'h41;
        if_addr = 8'h31;
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h40}) begin
            failures++;
            $display("FAIL cont_ex_first req/we/addr got %b/%b/%h want 1/0/40",
                mem_req, mem_we, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        step();
        mem_ack = 1'b0;
        checks++;
        if ({ex_done, if_done, ex_rdata, stall} !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin
            failures++;
            $display("FAIL cont_ex_done exd/ifd/rdata/stall got %b/%b/%h/%b want 1/0/5a/0",
                ex_done, if_done, ex_rdata, stall);
        end
        ex_req = 1'b0;
        if_addr = 8'h30;
        step();
        checks++;
        if ({mem_req, stall, ex_done} !== 3'b010) begin
            failures++;
            $display("FAIL cont_guard req/stall/exd got %b/%b/%b want 0/1/0",
                mem_req, stall, ex_done);
        end
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h30}) begin
            failures++;
            $display("FAIL cont_if_grant req/addr got %b/%h want 1/30",
                mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'hC3;
        step();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        checks++;
        if ({if_done, if_rdata, ex_rdata} !== {1'b1, 8'hC3, 8'h5A}) begin
            failures++;
            $display("FAIL cont_if_done done/ifr/exr got %b/%h/%h want 1/c3/5a",
                if_done, if_rdata, ex_rdata);
        end
        step();
        step();
        checks++;
        if ({n_if, n_ex, n_acc} !== {32'd1, 32'd1, 32'd2}) begin
            failures++;
            $display("FAIL cont_counts nif/nex/nacc got %0d/%0d/%0d want 1/1/2",
                n_if, n_ex, n_acc);
        end
    endtask

    task automatic test_held();
        clr_counts();
        if_req  = 1'b1;
        if_addr = 8'h50;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 8'h11;
        step();
        mem_ack = 1'b0;
        checks++;
        if ({if_done, if_rdata} !== {1'b1, 8'h11}) begin
            failures++;
            $display("FAIL held_done done/rdata got %b/%h want 1/11", if_done, if_rdata);
        end
        step();
        checks++;
        if ({mem_req, if_done, stall} !== 3'b001) begin
            failures++;
            $display("FAIL held_guard req/done/stall got %b/%b/%b want 0/0/1",
                mem_req, if_done, stall);
        end
        if_req = 1'b0;
        step();
        step();
        checks++;
        if ({n_if, n_acc, mem_req} !== {32'd1, 32'd1, 1'b0}) begin
            failures++;
            $display("FAIL held_counts nif/nacc/req got %0d/%0d/%b want 1/1/0",
                n_if, n_acc, mem_req);
        end
    endtask

    task automatic test_reset_mid();
        clr_counts();
        ex_req   = 1'b1;
        ex_we    = 1'b1;
        ex_addr  = 8'h60;
        ex_wdata = 8'h99;
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_req got %b want 0", mem_req);
        end
        ex_req   = 1'b0;
        ex_we    = 1'b0;
        ex_addr  = 8'h00;
        ex_wdata = 8'h00;
        mem_ack  = 1'b1;
        step();
        mem_ack = 1'b0;
        reset   = 1'b1;
        step();
        step();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_rdata, ex_rdata,
             if_done, ex_done, stall, err, n_ex} !== {46'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_mid_after outs=%h nex=%0d want 0/0",
                {mem_req, mem_we, mem_addr, mem_wdata, if_rdata, ex_rdata,
                 if_done, ex_done, stall, err}, n_ex);
        end
    endtask

    task automatic test_timeout();
        int n;
        if_req  = 1'b1;
        if_addr = 8'h50;
        step();
        mem_ack   = 1'b1;
        mem_rdata = 8'h6B;
        step();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        step();
        if_req  = 1'b1;
        if_addr = 8'h70;
        step();
        n = 0;
        while (mem_req && n < 30) begin
            n++;
            step();
        end
`ifdef MEM_TIMEOUT_EN
        checks++;
        if (n !== 15) begin
            failures++;
            $display("FAIL timeout_cycles got %0d want 15", n);
        end
        checks++;
        if ({if_done, if_rdata, err} !== {1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL timeout_done done/rdata/err got %b/%h/%b want 1/00/1",
                if_done, if_rdata, err);
        end
        if_req = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({err, mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_sticky err/req got %b/%b want 1/0", err, mem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_reset err got %b want 0", err);
        end
        step();
        reset = 1'b1;
        step();
`else
        checks++;
        if ({n, mem_req, err, if_rdata} !== {32'd30, 1'b1, 1'b0, 8'h6B}) begin
            failures++;
            $display("FAIL no_timeout n/req/err/rdata got %0d/%b/%b/%h want 30/1/0/6b",
                n, mem_req, err, if_rdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = 8'h42;
        step();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        checks++;
        if ({if_done, if_rdata, err} !== {1'b1, 8'h42, 1'b0}) begin
            failures++;
            $display("FAIL no_timeout_done done/rdata/err got %b/%h/%b want 1/42/0",
                if_done, if_rdata, err);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_held();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
